vrms_sqrt_scale: RTL and testbench

- Downstream stage of the mean-square measurement block. Takes each 22-bit mean-square result (sum of 256 squared ADC codes, shifted right by 8) when the measurement completes.
- Computes the floor integer square root with a sequential digit-by-digit restoring algorithm, which gives the RMS value in ADC codes.
- Scales the RMS value to millivolts and presents both results with a one-cycle valid strobe for the display/UART stage.

---
 rtl/vrms_sqrt_scale.sv | 81 ++++++++
 tb/tb_vrms_sqrt_scale.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vrms_sqrt_scale.sv
// vrms_sqrt_scale: sequential floor square root of the mean-square value, then scaling to millivolts.
// One root bit is produced per cycle; the result is presented with a one-cycle valid strobe.
module vrms_sqrt_scale #(
    parameter int IN_W        = 22,
    parameter int ROOT_W      = 11,
    parameter int VREF_MV     = 5000,
    parameter int SCALE_SHIFT = 12,
    parameter int MV_W        = 16
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              ms_valid,
    input  logic [IN_W-1:0]   ms_data,
    output logic              busy,
    output logic [ROOT_W-1:0] vrms_code,
    output logic [MV_W-1:0]   vrms_mv,
    output logic              vrms_valid,
    output logic              overrun
);
    localparam int OP_W   = 2 * ROOT_W;
    localparam int PROD_W = ROOT_W + 16;
    localparam int IT_W   = $clog2(ROOT_W);
    typedef enum logic [1:0] {IDLE, LOAD, CALC, SCALE} state_t;
    state_t              state;
    logic [OP_W-1:0]     op;
    logic [ROOT_W-1:0]   root;
    logic [ROOT_W+1:0]   rem;
    logic [ROOT_W+1:0]   rem_sh;
    logic [ROOT_W+1:0]   trial;
    logic [IT_W-1:0]     iter;
    logic [PROD_W-1:0]   prod;
    logic                ge;
    assign busy   = state != IDLE;
    assign rem_sh = (rem << 2) | (ROOT_W + 2)'(op[{iter, 1'b0} +: 2]);
    assign trial  = {root, 2'b01};
    assign ge     = rem_sh >= trial;
    // Rounded scaling: the +half LSB before the shift gives round-to-nearest millivolts.
    assign prod   = PROD_W'(root) * PROD_W'(VREF_MV) + PROD_W'(1 << (SCALE_SHIFT - 1));
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            root       <= '0;
            rem        <= '0;
            iter       <= '0;
            vrms_code  <= '0;
            vrms_mv    <= '0;
            vrms_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            vrms_valid <= 1'b0;
            if (ms_valid && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (ms_valid) state <= LOAD;
                LOAD: begin
                    op    <= OP_W'(ms_data);
                    root  <= '0;
                    rem   <= '0;
                    iter  <= IT_W'(ROOT_W - 1);
                    state <= CALC;
                end
                CALC: begin
                    rem  <= ge ? rem_sh - trial : rem_sh;
                    root <= {root[ROOT_W-2:0], ge};
                    if (iter == '0)
                        state <= SCALE;
                    else
                        iter <= iter - 1'b1;
                end
                SCALE: begin
                    vrms_code  <= root;
                    vrms_mv    <= MV_W'(prod >> SCALE_SHIFT);
                    vrms_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vrms_sqrt_scale.sv
// tb_vrms_sqrt_scale: scoreboard bench for the RMS square-root/scale stage.
// Expected results are queued when a value is sent and checked when vrms_valid fires.
module tb_vrms_sqrt_scale;
    logic        clk_sys;
    logic        rst_n;
    logic        ms_valid;
    logic [21:0] ms_data;
    logic        busy;
    logic [10:0] vrms_code;
    logic [15:0] vrms_mv;
    logic        vrms_valid;
    logic        overrun;

    typedef struct {int code; int mv;} exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;

    vrms_sqrt_scale dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .ms_valid(ms_valid), .ms_data(ms_data),
        .busy(busy), .vrms_code(vrms_code), .vrms_mv(vrms_mv),
        .vrms_valid(vrms_valid), .overrun(overrun)
    );

    initial begin
        clk_sys = 0;
        forever #5 clk_sys = ~clk_sys;
    end

    function automatic int isqrt(input int x);
        int r = 0;
        for (int b = 10; b >= 0; b--)
            if ((r | (1 << b)) * (r | (1 << b)) <= x) r = r | (1 << b);
        return r;
    endfunction

    function automatic int mv_of(input int r);
        return (r * 5000 + 2048) / 4096;
    endfunction

    always @(negedge clk_sys) begin
        if (vrms_valid) begin
            vld_cnt++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid code=%0d mv=%0d expected no strobe", vrms_code, vrms_mv);
            end else begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (vrms_code !== 11'(e.code)) begin
                    errors++;
                    $display("FAIL vrms_code got %0d expected %0d", vrms_code, e.code);
                end
                if (vrms_mv !== 16'(e.mv)) begin
                    errors++;
                    $display("FAIL vrms_mv got %0d expected %0d", vrms_mv, e.mv);
                end
            end
        end
    end

    task automatic send(input logic [21:0] d);
        @(negedge clk_sys);
        ms_valid = 1;
        q.push_back('{isqrt(int'(d)), mv_of(isqrt(int'(d)))});
        @(negedge clk_sys);
        ms_valid = 0;
        ms_data  = d;
    endtask

    task automatic pulse_only(input logic [21:0] d);
        @(negedge clk_sys);
        ms_valid = 1;
        ms_data  = d;
        @(negedge clk_sys);
        ms_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL wait_done timeout pending=%0d busy=%b", q.size(), busy);
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        ms_valid = 0;
        ms_data = 0;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({busy, vrms_valid, overrun, vrms_code, vrms_mv} !== '0) begin
            errors++;
            $display("FAIL reset busy=%b valid=%b ovr=%b code=%0d mv=%0d expected all 0",
                     busy, vrms_valid, overrun, vrms_code, vrms_mv);
        end
        rst_n = 1;
    endtask

    task automatic test_basic();
        send(22'd1048576);
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk_sys);
            checks++;
            if (busy !== (k <= 13) || vrms_valid !== (k == 14)) begin
                errors++;
                $display("FAIL latency cycle %0d busy=%b valid=%b expected busy=%b valid=%b",
                         k, busy, vrms_valid, k <= 13, k == 14);
            end
        end
        @(negedge clk_sys);
        checks++;
        if (vrms_valid !== 1'b0 || vrms_code !== 11'd1024 || vrms_mv !== 16'd1250) begin
            errors++;
            $display("FAIL hold valid=%b code=%0d mv=%0d expected 0/1024/1250", vrms_valid, vrms_code, vrms_mv);
        end
    endtask

    task automatic test_boundaries();
        send(22'd1046529); wait_done();
        send(22'd1048575); wait_done();
        send(22'd1000000); wait_done();
        checks++;
        if (vrms_code !== 11'd1000 || vrms_mv !== 16'd1221) begin
            errors++;
            $display("FAIL boundary_1e6 code=%0d mv=%0d expected 1000/1221", vrms_code, vrms_mv);
        end
    endtask

    task automatic test_extremes();
        int c0;
        c0 = vld_cnt;
        send(22'd0); wait_done();
        checks++;
        if (vld_cnt !== c0 + 1 || vrms_code !== 11'd0 || vrms_mv !== 16'd0) begin
            errors++;
            $display("FAIL zero_input strobes=%0d code=%0d mv=%0d expected 1/0/0", vld_cnt - c0, vrms_code, vrms_mv);
        end
        send(22'd4194303); wait_done();
        checks++;
        if (vrms_code !== 11'd2047 || vrms_mv !== 16'd2499) begin
            errors++;
            $display("FAIL max_input code=%0d mv=%0d expected 2047/2499", vrms_code, vrms_mv);
        end
        send(22'd8); wait_done();
    endtask

    task automatic test_overrun();
        int c0;
        c0 = vld_cnt;
        send(22'd250000);
        repeat (3) @(negedge clk_sys);
        pulse_only(22'd3000000);
        wait_done();
        repeat (20) @(negedge clk_sys);
        checks++;
        if (overrun !== 1'b1 || vld_cnt !== c0 + 1 || vrms_code !== 11'd500) begin
            errors++;
            $display("FAIL overrun ovr=%b strobes=%0d code=%0d expected 1/1/500", overrun, vld_cnt - c0, vrms_code);
        end
        send(22'd90000); wait_done();
        checks++;
        if (overrun !== 1'b1 || vrms_code !== 11'd300) begin
            errors++;
            $display("FAIL overrun_sticky ovr=%b code=%0d expected 1/300", overrun, vrms_code);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        send(22'd1234567);
        repeat (6) @(negedge clk_sys);
        rst_n = 0;
        q.delete();
        c0 = vld_cnt;
        @(negedge clk_sys);
        checks++;
        if ({busy, vrms_valid, overrun, vrms_code, vrms_mv} !== '0) begin
            errors++;
            $display("FAIL reset_mid busy=%b valid=%b ovr=%b code=%0d mv=%0d expected all 0",
                     busy, vrms_valid, overrun, vrms_code, vrms_mv);
        end
        rst_n = 1;
        repeat (15) @(negedge clk_sys);
        checks++;
        if (vld_cnt !== c0) begin
            errors++;
            $display("FAIL reset_abort strobes=%0d expected 0", vld_cnt - c0);
        end
        send(22'd4096); wait_done();
        checks++;
        if (vrms_code !== 11'd64 || vrms_mv !== 16'd78) begin
            errors++;
            $display("FAIL after_reset code=%0d mv=%0d expected 64/78", vrms_code, vrms_mv);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = vld_cnt;
        for (int i = 0; i < 400; i++) begin
            send(22'($urandom_range(0, 4194303)));
            repeat (14) @(negedge clk_sys);
        end
        wait_done();
        checks++;
        if (overrun !== 1'b0 || vld_cnt !== c0 + 400) begin
            errors++;
            $display("FAIL back_to_back ovr=%b strobes=%0d expected 0/400", overrun, vld_cnt - c0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_extremes();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk_sys);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
